// File: rtl/fetch_ctl_pkg.sv
// Shared types and constants for the fetch/branch-control stage.
// Used by the stage itself and by the branch decoder.
package fetch_ctl_pkg;

  localparam int IW_DEF = 9;
  localparam int AW_DEF = 16;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [1:0] JM_STEP = 2'd0;
  localparam logic [1:0] JM_SKIP = 2'd1;
  localparam logic [1:0] JM_SKNZ = 2'd2;
  localparam logic [1:0] JM_JUMP = 2'd3;

  localparam logic [2:0] OP_BR      = 3'b111;
  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  localparam logic [1:0] SUB_SKP  = 2'b00;
  localparam logic [1:0] SUB_SKNZ = 2'b01;
  localparam logic [1:0] SUB_JMP  = 2'b10;
  localparam logic [1:0] SUB_EXT  = 2'b11;

  typedef struct packed {
    logic [1:0]  jump_mode;
    logic        cond_skip_enable;
    logic [15:0] skip_amount;
    logic [7:0]  jump_addr;
  } br_ctl_t;

endpackage

// File: rtl/fetch_ctl_blk_br_decode.sv
// Combinational branch decoder: instruction + zero flag to pc controls.
// Shared with the disassembler/trace monitor.
module br_decode
  import fetch_ctl_pkg::*;
(
  input  logic [8:0] instr,
  input  logic       flag_zero,
  output br_ctl_t    ctl,
  output logic       is_halt
);

  logic       is_br;
  logic [1:0] sub;
  logic [3:0] imm;

  assign is_br = (instr[8:6] == OP_BR);
  assign sub   = instr[5:4];
  assign imm   = instr[3:0];

  // Map the branch sub-op to pc_blk controls; SUB_EXT is a plain step.
  always_comb begin
    ctl     = '0;
    is_halt = (instr == HALT_INSTR);
    unique case (1'b1)
      (is_br && sub == SUB_SKP): begin
        ctl.jump_mode   = JM_SKIP;
        ctl.skip_amount = {12'h000, imm};
      end
      (is_br && sub == SUB_SKNZ): begin
        ctl.jump_mode        = JM_SKNZ;
        ctl.skip_amount      = {12'h000, imm};
        ctl.cond_skip_enable = ~flag_zero;
      end
      (is_br && sub == SUB_JMP): begin
        ctl.jump_mode = JM_JUMP;
        ctl.jump_addr = {4'h0, imm};
      end
      default: ctl.jump_mode = JM_STEP;
    endcase
  end

endmodule

// File: rtl/fetch_ctl_blk.sv
// Fetch/branch-control stage: two-cycle FETCH/EXEC sequencer feeding
// pc_blk, plus run/halt control and a retired-instruction counter.
module fetch_ctl_blk
  import fetch_ctl_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  input  logic [AW-1:0] cur_instr_addr,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          flag_zero,
  output logic          pc_enable,
  output logic [1:0]    jump_mode,
  output logic          cond_skip_enable,
  output logic [15:0]   skip_amount,
  output logic [7:0]    jump_addr,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic [CW-1:0] retired,
  output logic          done
);

  state_e        state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] ret_q, ret_d;

  br_ctl_t dec_ctl;
  logic    dec_halt;
  logic    in_exec;
  logic    retire;

  assign imem_addr = cur_instr_addr;

  br_decode u_dec (
    .instr     (imem_rdata[8:0]),
    .flag_zero (flag_zero),
    .ctl       (dec_ctl),
    .is_halt   (dec_halt)
  );

  assign in_exec = (state_q == ST_EXEC);
  assign retire  = in_exec & enable & ~dec_halt;

  // pc_blk controls are only live during EXEC.
  always_comb begin
    pc_enable        = retire;
    jump_mode        = JM_STEP;
    cond_skip_enable = 1'b0;
    skip_amount      = '0;
    jump_addr        = '0;
    if (in_exec) begin
      jump_mode        = dec_ctl.jump_mode;
      cond_skip_enable = dec_ctl.cond_skip_enable;
      skip_amount      = dec_ctl.skip_amount;
      jump_addr        = dec_ctl.jump_addr;
    end
  end

  // Next-state: sequencer, retire capture and saturating counter.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    ret_d   = ret_q;
    if (enable) begin
      valid_d = retire;
      if (retire) begin
        instr_d = imem_rdata;
        if (ret_q != '1) ret_d = ret_q + {{(CW-1){1'b0}}, 1'b1};
      end
      unique case (state_q)
        ST_IDLE:  if (start) state_d = ST_FETCH;
        ST_FETCH: state_d = ST_EXEC;
        ST_EXEC:  state_d = dec_halt ? ST_HALT : ST_FETCH;
        ST_HALT:  state_d = ST_HALT;
      endcase
    end
  end

  // State registers; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      ret_q   <= ret_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign retired     = ret_q;
  assign done        = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_ctl_blk.sv
// Bench for fetch_ctl_blk: directed scenarios plus a randomized run
// against a behavioural model of the fetch/exec sequencing.
module tb_fetch_ctl_blk;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [15:0] cur_instr_addr;
  logic [15:0] imem_addr;
  logic [8:0]  imem_rdata;
  logic        flag_zero;
  logic        pc_enable;
  logic [1:0]  jump_mode;
  logic        cond_skip_enable;
  logic [15:0] skip_amount;
  logic [7:0]  jump_addr;
  logic [8:0]  instr;
  logic        instr_valid;
  logic [15:0] retired;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [8:0] rom [256];

  fetch_ctl_blk dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .start            (start),
    .cur_instr_addr   (cur_instr_addr),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .flag_zero        (flag_zero),
    .pc_enable        (pc_enable),
    .jump_mode        (jump_mode),
    .cond_skip_enable (cond_skip_enable),
    .skip_amount      (skip_amount),
    .jump_addr        (jump_addr),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .retired          (retired),
    .done             (done)
  );

  always #5 clk = ~clk;

  // synchronous ROM, 1-cycle latency
  always @(posedge clk) imem_rdata <= rom[cur_instr_addr[7:0]];

  // minimal pc_blk stand-in: advances by one per enabled EXEC
  always @(posedge clk or negedge reset)
    if (!reset) cur_instr_addr <= 16'h0;
    else if (pc_enable) cur_instr_addr <= cur_instr_addr + 16'h1;

  function automatic void ref_dec(input int w, input bit fz,
                                  output int jm, output int sk,
                                  output int ja, output bit cse,
                                  output bit hlt);
    jm = 0; sk = 0; ja = 0; cse = 0;
    hlt = (w == 511);
    if (w / 64 == 7) begin
      case ((w / 16) % 4)
        0: begin jm = 1; sk = w % 16; end
        1: begin jm = 2; sk = w % 16; cse = !fz; end
        2: begin jm = 3; ja = w % 16; end
        default: ;
      endcase
    end
  endfunction

  task automatic do_reset();
    reset = 1'b0; enable = 1'b1; start = 1'b0; flag_zero = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // leaves the caller at the negedge inside FETCH
  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; start = 1'b0; flag_zero = 1'b0;
    #3;
    checks++; if (pc_enable !== 1'b0) begin errors++;
      $display("FAIL rst_pc_en got %0b want 0", pc_enable); end
    checks++; if (jump_mode !== 2'd0) begin errors++;
      $display("FAIL rst_jm got %0d want 0", jump_mode); end
    checks++; if (instr !== 9'h0) begin errors++;
      $display("FAIL rst_instr got %0h want 0", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid got %0b want 0", instr_valid); end
    checks++; if (retired !== 16'd0) begin errors++;
      $display("FAIL rst_retired got %0d want 0", retired); end
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL rst_done got %0b want 0", done); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_steps();
    int pe_cnt = 0;
    int v_cnt = 0;
    rom[0] = 9'h000; rom[1] = 9'h000; rom[2] = 9'h000;
    do_reset();
    start_run();
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++; if (pc_enable !== 1'((k % 2) == 0)) begin errors++;
        $display("FAIL step_pc_en k=%0d got %0b want %0b",
                 k, pc_enable, (k % 2) == 0); end
      checks++; if (jump_mode !== 2'd0) begin errors++;
        $display("FAIL step_jm k=%0d got %0d want 0", k, jump_mode); end
      if (pc_enable === 1'b1) pe_cnt++;
      if (instr_valid === 1'b1) v_cnt++;
      @(negedge clk);
    end
    checks++; if (retired !== 16'd2) begin errors++;
      $display("FAIL step_retired got %0d want 2", retired); end
    checks++; if (v_cnt != 2) begin errors++;
      $display("FAIL step_valid_pulses got %0d want 2", v_cnt); end
    checks++; if (pe_cnt != 2) begin errors++;
      $display("FAIL step_pc_pulses got %0d want 2", pe_cnt); end
  endtask

  task automatic test_skp();
    rom[0] = 9'h1C4;
    do_reset();
    start_run();
    @(negedge clk); #1;
    checks++; if (jump_mode !== 2'd1) begin errors++;
      $display("FAIL skp_jm got %0d want 1", jump_mode); end
    checks++; if (skip_amount !== 16'd4) begin errors++;
      $display("FAIL skp_amt got %0d want 4", skip_amount); end
    checks++; if (pc_enable !== 1'b1) begin errors++;
      $display("FAIL skp_pc_en got %0b want 1", pc_enable); end
    @(negedge clk); #1;
    checks++; if (instr !== 9'h1C4) begin errors++;
      $display("FAIL skp_instr got %0h want 1c4", instr); end
    checks++; if (jump_mode !== 2'd0) begin errors++;
      $display("FAIL skp_jm_fetch got %0d want 0", jump_mode); end
  endtask

  task automatic test_sknz();
    for (int f = 0; f < 2; f++) begin
      rom[0] = 9'h1D3;
      do_reset();
      flag_zero = 1'(f);
      start_run();
      @(negedge clk); #1;
      checks++; if (jump_mode !== 2'd2) begin errors++;
        $display("FAIL sknz_jm fz=%0d got %0d want 2", f, jump_mode); end
      checks++; if (cond_skip_enable !== 1'(f == 0)) begin errors++;
        $display("FAIL sknz_cse fz=%0d got %0b want %0b",
                 f, cond_skip_enable, f == 0); end
      checks++; if (skip_amount !== 16'd3) begin errors++;
        $display("FAIL sknz_amt fz=%0d got %0d want 3", f, skip_amount); end
    end
  endtask

  task automatic test_jmp_reserved();
    rom[0] = 9'h1E9;
    do_reset();
    start_run();
    @(negedge clk); #1;
    checks++; if (jump_mode !== 2'd3) begin errors++;
      $display("FAIL jmp_jm got %0d want 3", jump_mode); end
    checks++; if (jump_addr !== 8'd9) begin errors++;
      $display("FAIL jmp_addr got %0d want 9", jump_addr); end
    rom[0] = 9'h1FE;
    do_reset();
    start_run();
    @(negedge clk); #1;
    checks++; if (jump_mode !== 2'd0) begin errors++;
      $display("FAIL rsv_jm got %0d want 0", jump_mode); end
    checks++; if (pc_enable !== 1'b1) begin errors++;
      $display("FAIL rsv_pc_en got %0b want 1", pc_enable); end
  endtask

  task automatic test_halt();
    rom[0] = 9'h1FF;
    do_reset();
    start_run();
    @(negedge clk); #1;
    checks++; if (pc_enable !== 1'b0) begin errors++;
      $display("FAIL halt_pc_en got %0b want 0", pc_enable); end
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL halt_done_exec got %0b want 0", done); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1) begin errors++;
      $display("FAIL halt_done got %0b want 1", done); end
    checks++; if (retired !== 16'd0) begin errors++;
      $display("FAIL halt_retired got %0d want 0", retired); end
    checks++; if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL halt_valid got %0b want 0", instr_valid); end
    checks++; if (instr !== 9'h0) begin errors++;
      $display("FAIL halt_instr got %0h want 0", instr); end
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    #1;
    checks++; if (done !== 1'b1) begin errors++;
      $display("FAIL halt_sticky got %0b want 1", done); end
    checks++; if (pc_enable !== 1'b0) begin errors++;
      $display("FAIL halt_sticky_pc got %0b want 0", pc_enable); end
    #1 reset = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL halt_async_clr got %0b want 0", done); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_stall();
    rom[0] = 9'h1C4;
    do_reset();
    start_run();
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pc_enable !== 1'b0) begin errors++;
        $display("FAIL stall_pc_en i=%0d got %0b want 0", i, pc_enable); end
      checks++; if (jump_mode !== 2'd1) begin errors++;
        $display("FAIL stall_jm i=%0d got %0d want 1", i, jump_mode); end
      checks++; if (retired !== 16'd0) begin errors++;
        $display("FAIL stall_ret i=%0d got %0d want 0", i, retired); end
      @(negedge clk);
    end
    enable = 1'b1;
    #1;
    checks++; if (pc_enable !== 1'b1) begin errors++;
      $display("FAIL stall_resume got %0b want 1", pc_enable); end
    @(negedge clk); #1;
    checks++; if (retired !== 16'd1) begin errors++;
      $display("FAIL stall_ret1 got %0d want 1", retired); end
    checks++; if (instr_valid !== 1'b1) begin errors++;
      $display("FAIL stall_valid got %0b want 1", instr_valid); end
    @(negedge clk); #1;
    checks++; if (retired !== 16'd1) begin errors++;
      $display("FAIL stall_once got %0d want 1", retired); end
    checks++; if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL stall_pulse got %0b want 0", instr_valid); end
  endtask

  task automatic test_reset_midfetch();
    rom[0] = 9'h000; rom[1] = 9'h1C4;
    do_reset();
    start_run();
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (retired !== 16'd0) begin errors++;
      $display("FAIL mid_ret got %0d want 0", retired); end
    checks++; if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL mid_valid got %0b want 0", instr_valid); end
    checks++; if (pc_enable !== 1'b0 || jump_mode !== 2'd0) begin errors++;
      $display("FAIL mid_ctl got %0b/%0d want 0/0", pc_enable, jump_mode); end
    checks++; if (imem_addr !== 16'd0) begin errors++;
      $display("FAIL mid_addr got %0d want 0", imem_addr); end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (pc_enable !== 1'b0 || instr_valid !== 1'b0) begin errors++;
      $display("FAIL mid_idle got %0b/%0b want 0/0", pc_enable, instr_valid); end
  endtask

  task automatic test_random();
    int p, pc, ei, ev, er;
    int w, jm, sk, ja;
    bit cse, hlt, en, st, fz, ex;
    for (int i = 0; i < 256; i++) begin
      case ($urandom % 8)
        0, 1, 2: rom[i] = {3'($urandom % 7), 6'($urandom)};
        3: rom[i] = {5'b111_00, 4'($urandom)};
        4: rom[i] = {5'b111_01, 4'($urandom)};
        5: rom[i] = {5'b111_10, 4'($urandom)};
        6: rom[i] = {5'b111_11, 4'($urandom % 15)};
        default: rom[i] = ($urandom % 4 == 0) ? 9'h1FF : 9'h000;
      endcase
    end
    do_reset();
    p = 0; pc = 0; ei = 0; ev = 0; er = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      en = ($urandom % 4) != 0;
      st = ($urandom % 3) == 0;
      fz = $urandom % 2;
      enable = en; start = st; flag_zero = fz;
      #1;
      w = rom[pc % 256];
      ref_dec(w, fz, jm, sk, ja, cse, hlt);
      ex = (p == 2);
      checks++; if (pc_enable !== 1'(ex && en && !hlt)) begin errors++;
        $display("FAIL rnd_pc_en c=%0d got %0b want %0b",
                 c, pc_enable, ex && en && !hlt); end
      checks++; if (jump_mode !== 2'(ex ? jm : 0)) begin errors++;
        $display("FAIL rnd_jm c=%0d got %0d want %0d",
                 c, jump_mode, ex ? jm : 0); end
      checks++; if (cond_skip_enable !== 1'(ex && cse)) begin errors++;
        $display("FAIL rnd_cse c=%0d got %0b want %0b",
                 c, cond_skip_enable, ex && cse); end
      checks++; if (skip_amount !== 16'(ex ? sk : 0)) begin errors++;
        $display("FAIL rnd_skip c=%0d got %0d want %0d",
                 c, skip_amount, ex ? sk : 0); end
      checks++; if (jump_addr !== 8'(ex ? ja : 0)) begin errors++;
        $display("FAIL rnd_jaddr c=%0d got %0d want %0d",
                 c, jump_addr, ex ? ja : 0); end
      checks++; if (instr !== 9'(ei)) begin errors++;
        $display("FAIL rnd_instr c=%0d got %0h want %0h", c, instr, ei); end
      checks++; if (instr_valid !== 1'(ev)) begin errors++;
        $display("FAIL rnd_valid c=%0d got %0b want %0d",
                 c, instr_valid, ev); end
      checks++; if (retired !== 16'(er)) begin errors++;
        $display("FAIL rnd_retired c=%0d got %0d want %0d", c, retired, er); end
      checks++; if (done !== 1'(p == 3)) begin errors++;
        $display("FAIL rnd_done c=%0d got %0b want %0b", c, done, p == 3); end
      checks++; if (imem_addr !== 16'(pc)) begin errors++;
        $display("FAIL rnd_addr c=%0d got %0d want %0d", c, imem_addr, pc); end
      @(posedge clk);
      if (en) begin
        ev = ex && !hlt;
        if (ev != 0) begin
          ei = w;
          if (er < 65535) er++;
          pc = (pc + 1) % 65536;
        end
        case (p)
          0: if (st) p = 1;
          1: p = 2;
          2: p = hlt ? 3 : 1;
          default: p = 3;
        endcase
      end
      if (p == 3 && ($urandom % 5) == 0) begin
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        p = 0; pc = 0; ei = 0; ev = 0; er = 0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'h000;
    reset = 1'b0; enable = 1'b1; start = 1'b0; flag_zero = 1'b0;
    test_reset();
    test_steps();
    test_skp();
    test_sknz();
    test_jmp_reserved();
    test_halt();
    test_stall();
    test_reset_midfetch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
